// File: rtl/symbol_fifo.sv
// ---------------------------------------------------------------------------
// symbol_fifo
//
// Synchronous FIFO of DATA_W-bit symbols with optional serial (LSB-first)
// read-out and optional rising-edge qualification of the write/read requests.
// Status flags are registered from the next-state occupancy, so they always
// agree with outLevel in the same cycle.
//
// Parameters
//   DATA_W    symbol width (2..16)
//   DEPTH     number of entries (power of two, 4..256)
//   AF_LEVEL  outAlmostFull when outLevel >= AF_LEVEL
//   AE_LEVEL  outAlmostEmpty when outLevel <= AE_LEVEL
//   SER_MODE  0 = one symbol per read, 1 = one bit per read (LSB first)
//   EDGE_EN   1 = enables act on their rising edge only
//
// Ports
//   inClock         clock, rising edge
//   inReset         asynchronous reset, active high
//   inClear         synchronous flush (sticky error flags are kept)
//   inWriteEnable   write request, inData is the symbol written
//   inReadEnable    read request (symbol or bit depending on SER_MODE)
//   outData         last symbol read / symbol being serialised
//   outBit          last serial bit read (0 in parallel mode)
//   outValid        one-cycle pulse for each new outData/outBit
//   outFull, outEmpty, outAlmostFull, outAlmostEmpty   occupancy status
//   outLevel        number of stored symbols
//   outOverflow, outUnderflow   sticky error flags
// ---------------------------------------------------------------------------
module symbol_fifo #(
   parameter int DATA_W   = 4,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int SER_MODE = 0,
   parameter int EDGE_EN  = 0
) (
   input  logic                     inClock,
   input  logic                     inReset,
   input  logic                     inClear,
   input  logic                     inWriteEnable,
   input  logic [DATA_W-1:0]        inData,
   input  logic                     inReadEnable,
   output logic [DATA_W-1:0]        outData,
   output logic                     outBit,
   output logic                     outValid,
   output logic                     outFull,
   output logic                     outEmpty,
   output logic                     outAlmostFull,
   output logic                     outAlmostEmpty,
   output logic [$clog2(DEPTH):0]   outLevel,
   output logic                     outOverflow,
   output logic                     outUnderflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  bitCnt;
   logic [DATA_W-1:0] shiftReg;
   logic              wrPrev;
   logic              rdPrev;

   logic              effWr;
   logic              effRd;
   logic              canPop;
   logic              doPop;
   logic              doShift;
   logic              doPush;
   logic [LVL_W-1:0]  levelNext;

   always_comb begin
      effWr = (EDGE_EN != 0) ? (inWriteEnable & ~wrPrev) : inWriteEnable;
      effRd = (EDGE_EN != 0) ? (inReadEnable & ~rdPrev) : inReadEnable;

      // In serial mode a new symbol is only fetched once the previous one
      // has been fully shifted out.
      canPop  = ~outEmpty & ((SER_MODE == 0) | (bitCnt == '0));
      doPop   = effRd & canPop;
      doShift = effRd & (SER_MODE != 0) & (bitCnt != '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      doPush  = effWr & (~outFull | doPop);

      levelNext = outLevel;
      if (inClear) begin
         levelNext = '0;
      end else if (doPush && !doPop) begin
         levelNext = outLevel + LVL_W'(1);
      end else if (doPop && !doPush) begin
         levelNext = outLevel - LVL_W'(1);
      end
   end

   // Storage is deliberately not reset so it maps onto block RAM.
   always_ff @(posedge inClock) begin
      if (doPush && !inClear) begin
         mem[wrPtr] <= inData;
      end
   end

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         wrPtr          <= '0;
         rdPtr          <= '0;
         bitCnt         <= '0;
         shiftReg       <= '0;
         wrPrev         <= 1'b0;
         rdPrev         <= 1'b0;
         outData        <= '0;
         outBit         <= 1'b0;
         outValid       <= 1'b0;
         outLevel       <= '0;
         outFull        <= 1'b0;
         outEmpty       <= 1'b1;
         outAlmostFull  <= (AF_LEVEL <= 0);
         outAlmostEmpty <= (AE_LEVEL >= 0);
         outOverflow    <= 1'b0;
         outUnderflow   <= 1'b0;
      end else begin
         wrPrev   <= inWriteEnable;
         rdPrev   <= inReadEnable;
         outValid <= 1'b0;

         outLevel       <= levelNext;
         outFull        <= (levelNext == LVL_W'(DEPTH));
         outEmpty       <= (levelNext == '0);
         outAlmostFull  <= (levelNext >= LVL_W'(AF_LEVEL));
         outAlmostEmpty <= (levelNext <= LVL_W'(AE_LEVEL));

         if (inClear) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            bitCnt <= '0;
         end else begin
            if (doPush) begin
               wrPtr <= wrPtr + PTR_W'(1);
            end

            if (doPop) begin
               rdPtr    <= rdPtr + PTR_W'(1);
               outData  <= mem[rdPtr];
               outValid <= 1'b1;
               if (SER_MODE != 0) begin
                  // Bit 0 goes out now; the shift register keeps the rest.
                  outBit   <= mem[rdPtr][0];
                  shiftReg <= mem[rdPtr] >> 1;
                  bitCnt   <= CNT_W'(DATA_W - 1);
               end
            end else if (doShift) begin
               outBit   <= shiftReg[0];
               shiftReg <= shiftReg >> 1;
               bitCnt   <= bitCnt - CNT_W'(1);
               outValid <= 1'b1;
            end

            if (effWr && outFull && !doPop) begin
               outOverflow <= 1'b1;
            end
            if (effRd && !doPop && !doShift) begin
               outUnderflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_symbol_fifo.sv
// ---------------------------------------------------------------------------
// tb_symbol_fifo
//
// Three symbol_fifo instances share one stimulus stream:
//   u0 defaults (parallel, level enables)
//   u1 SER_MODE=1 (serial bit read-out)
//   u2 EDGE_EN=1  (rising-edge enables)
// A queue-based reference model per instance predicts occupancy, sticky
// flags and every read response. Responses go into expectation queues that
// a negedge monitor drains whenever outValid is seen.
// ---------------------------------------------------------------------------
module tb_symbol_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic       wr  = 1'b0;
   logic       rd  = 1'b0;
   logic [3:0] din = '0;

   logic [3:0] d0, d1, d2;
   logic       b0, b1, b2;
   logic       v0, v1, v2;
   logic       f0, f1, f2;
   logic       em0, em1, em2;
   logic       af0, af1, af2;
   logic       ae0, ae1, ae2;
   logic [4:0] l0, l1, l2;
   logic       ov0, ov1, ov2;
   logic       un0, un1, un2;

   symbol_fifo u0 (
      .inClock(clk), .inReset(rst), .inClear(clr), .inWriteEnable(wr), .inData(din),
      .inReadEnable(rd), .outData(d0), .outBit(b0), .outValid(v0), .outFull(f0),
      .outEmpty(em0), .outAlmostFull(af0), .outAlmostEmpty(ae0), .outLevel(l0),
      .outOverflow(ov0), .outUnderflow(un0));

   symbol_fifo #(.SER_MODE(1)) u1 (
      .inClock(clk), .inReset(rst), .inClear(clr), .inWriteEnable(wr), .inData(din),
      .inReadEnable(rd), .outData(d1), .outBit(b1), .outValid(v1), .outFull(f1),
      .outEmpty(em1), .outAlmostFull(af1), .outAlmostEmpty(ae1), .outLevel(l1),
      .outOverflow(ov1), .outUnderflow(un1));

   symbol_fifo #(.EDGE_EN(1)) u2 (
      .inClock(clk), .inReset(rst), .inClear(clr), .inWriteEnable(wr), .inData(din),
      .inReadEnable(rd), .outData(d2), .outBit(b2), .outValid(v2), .outFull(f2),
      .outEmpty(em2), .outAlmostFull(af2), .outAlmostEmpty(ae2), .outLevel(l2),
      .outOverflow(ov2), .outUnderflow(un2));

   int nChk  = 0;
   int nFail = 0;

   typedef struct {
      int d;
      int b;
   } exp_t;

   // Reference model state
   int   q0[$];
   int   q1[$];
   int   q2[$];
   int   bq1[$];
   int   sym1 = 0;
   bit   mov[3];
   bit   mun[3];
   bit   prevW = 1'b0;
   bit   prevR = 1'b0;
   exp_t e0[$];
   exp_t e1[$];
   exp_t e2[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      nChk++;
      if (act !== expv) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic chkInst(input string n, input logic [4:0] l, input logic f, input logic e,
                          input logic af, input logic ae, input logic ov, input logic un,
                          input int sz, input bit mo, input bit mu);
      chk({n, " level"}, 32'(l), sz);
      chk({n, " full"}, 32'(f), 32'(sz == 16));
      chk({n, " empty"}, 32'(e), 32'(sz == 0));
      chk({n, " almostFull"}, 32'(af), 32'(sz >= 14));
      chk({n, " almostEmpty"}, 32'(ae), 32'(sz <= 2));
      chk({n, " overflow"}, 32'(ov), 32'(mo));
      chk({n, " underflow"}, 32'(un), 32'(mu));
   endtask

   task automatic chkReset(input string n, input logic [3:0] d, input logic b, input logic v,
                           input logic [4:0] l, input logic f, input logic e, input logic af,
                           input logic ae, input logic ov, input logic un);
      chk({n, " rst data"}, 32'(d), 0);
      chk({n, " rst bit"}, 32'(b), 0);
      chk({n, " rst valid"}, 32'(v), 0);
      chk({n, " rst level"}, 32'(l), 0);
      chk({n, " rst full"}, 32'(f), 0);
      chk({n, " rst empty"}, 32'(e), 1);
      chk({n, " rst almostFull"}, 32'(af), 0);
      chk({n, " rst almostEmpty"}, 32'(ae), 1);
      chk({n, " rst overflow"}, 32'(ov), 0);
      chk({n, " rst underflow"}, 32'(un), 0);
   endtask

   // Apply one cycle of stimulus, then advance the model and check status.
   task automatic step(input bit w, input bit r, input bit c, input int d);
      int sz;
      int h;
      bit pop;
      bit push;
      bit ew;
      bit er;
      wr  = w;
      rd  = r;
      clr = c;
      din = d[3:0];
      @(posedge clk);
      #1;
      // u0: plain parallel FIFO
      if (c) begin
         q0.delete();
      end else begin
         sz   = q0.size();
         pop  = r && sz > 0;
         push = w && (sz < 16 || pop);
         if (r && !pop) mun[0] = 1'b1;
         if (w && !push) mov[0] = 1'b1;
         if (pop) begin
            h = q0.pop_front();
            e0.push_back('{h, 0});
         end
         if (push) q0.push_back(d);
      end
      // u2: same FIFO, requests qualified by their rising edge
      ew    = w && !prevW;
      er    = r && !prevR;
      prevW = w;
      prevR = r;
      if (c) begin
         q2.delete();
      end else begin
         sz   = q2.size();
         pop  = er && sz > 0;
         push = ew && (sz < 16 || pop);
         if (er && !pop) mun[2] = 1'b1;
         if (ew && !push) mov[2] = 1'b1;
         if (pop) begin
            h = q2.pop_front();
            e2.push_back('{h, 0});
         end
         if (push) q2.push_back(d);
      end
      // u1: symbols turn into a stream of bits, LSB first
      if (c) begin
         q1.delete();
         bq1.delete();
      end else begin
         sz  = q1.size();
         pop = 1'b0;
         if (r) begin
            if (bq1.size() > 0) begin
               h = bq1.pop_front();
               e1.push_back('{sym1, h});
            end else if (sz > 0) begin
               pop = 1'b1;
            end else begin
               mun[1] = 1'b1;
            end
         end
         push = w && (sz < 16 || pop);
         if (w && !push) mov[1] = 1'b1;
         if (pop) begin
            sym1 = q1.pop_front();
            for (int i = 1; i < 4; i++) bq1.push_back((sym1 >> i) & 1);
            e1.push_back('{sym1, sym1 & 1});
         end
         if (push) q1.push_back(d);
      end
      chkInst("u0", l0, f0, em0, af0, ae0, ov0, un0, q0.size(), mov[0], mun[0]);
      chkInst("u1", l1, f1, em1, af1, ae1, ov1, un1, q1.size(), mov[1], mun[1]);
      chkInst("u2", l2, f2, em2, af2, ae2, ov2, un2, q2.size(), mov[2], mun[2]);
   endtask

   // Assert reset dly time units from now, check outputs before any clock
   // edge, then release between edges.
   task automatic doReset(input int dly);
      #(dly);
      rst = 1'b1;
      wr  = 1'b0;
      rd  = 1'b0;
      clr = 1'b0;
      #1;
      chkReset("u0", d0, b0, v0, l0, f0, em0, af0, ae0, ov0, un0);
      chkReset("u1", d1, b1, v1, l1, f1, em1, af1, ae1, ov1, un1);
      chkReset("u2", d2, b2, v2, l2, f2, em2, af2, ae2, ov2, un2);
      q0.delete();
      q1.delete();
      q2.delete();
      bq1.delete();
      e0.delete();
      e1.delete();
      e2.delete();
      for (int i = 0; i < 3; i++) begin
         mov[i] = 1'b0;
         mun[i] = 1'b0;
      end
      prevW = 1'b0;
      prevR = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   // Monitor: every pushed expectation must be matched by outValid at the
   // very next negedge, and every outValid must have an expectation.
   always @(negedge clk) begin : monitor
      exp_t x;
      if (!rst) begin
         if (v0) begin
            if (e0.size() == 0) begin
               nChk++; nFail++;
               $display("FAIL u0 spurious valid: data %0d, none expected", d0);
            end else begin
               x = e0.pop_front();
               chk("u0 outData", 32'(d0), x.d);
               chk("u0 outBit", 32'(b0), x.b);
            end
         end
         if (v1) begin
            if (e1.size() == 0) begin
               nChk++; nFail++;
               $display("FAIL u1 spurious valid: bit %0d, none expected", b1);
            end else begin
               x = e1.pop_front();
               chk("u1 outData", 32'(d1), x.d);
               chk("u1 outBit", 32'(b1), x.b);
            end
         end
         if (v2) begin
            if (e2.size() == 0) begin
               nChk++; nFail++;
               $display("FAIL u2 spurious valid: data %0d, none expected", d2);
            end else begin
               x = e2.pop_front();
               chk("u2 outData", 32'(d2), x.d);
               chk("u2 outBit", 32'(b2), x.b);
            end
         end
         chk("u0 pending reads", e0.size(), 0);
         chk("u1 pending reads", e1.size(), 0);
         chk("u2 pending reads", e2.size(), 0);
         e0.delete();
         e1.delete();
         e2.delete();
      end
   end

   initial begin
      doReset(2);

      // Three writes then three reads
      step(1, 0, 0, 4'h1);
      step(1, 0, 0, 4'h4);
      step(1, 0, 0, 4'h9);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      chk("u0 empty after 3 reads", 32'(em0), 1);

      // Serial read of 0xD, then one read too many
      step(0, 0, 1, 0);
      step(1, 0, 0, 4'hD);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      chk("u1 underflow after 5th read", 32'(un1), 1);
      chk("u1 valid after 5th read", 32'(v1), 0);

      // Fill past full
      step(0, 0, 1, 0);
      for (int k = 1; k <= 17; k++) begin
         step(1, 0, 0, k & 15);
         chk($sformatf("u0 almostFull at write %0d", k), 32'(af0), 32'(k >= 14));
         chk($sformatf("u0 full at write %0d", k), 32'(f0), 32'(k >= 16));
      end
      chk("u0 level when full", 32'(l0), 16);
      chk("u0 overflow", 32'(ov0), 1);

      // Simultaneous read+write while full, then drain
      step(1, 1, 0, 4'hA);
      chk("u0 level after full r+w", 32'(l0), 16);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
      chk("u0 empty after drain", 32'(em0), 1);

      // Held write enable with edge qualification
      step(0, 0, 1, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 4'h6);
      chk("u2 level after held write", 32'(l2), 1);
      step(0, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 3, $urandom_range(0, 15));
      end

      // Reset in the middle of serialising a symbol, then refill and read
      step(0, 0, 1, 0);
      step(1, 0, 0, 4'hB);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      doReset(3);
      step(1, 0, 0, 4'h3);
      step(0, 0, 0, 0);
      step(1, 0, 0, 4'hC);
      for (int i = 0; i < 10; i++) step(0, i % 2 == 0, 0, 0);
      step(0, 0, 0, 0);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
